fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the ARMINx8 core. Owns the program counter that addresses the 9-bit instruction ROM, registers the returned instruction for decode, and handles start, stall, absolute jump, PC-relative branch and halt. Sits between the top-level test harness (Start/Done) and the ROM/decoder pair. Also provides a cycle counter for run-length measurement.

## Interface
- D, 12, PC / ROM address width
- HALT_CODE, 9'h1FF, machine code that terminates the program
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin execution at StartAddr; honoured only in IDLE or HALT
- StartAddr  in  D  first instruction address
- Stall  in  1  hold fetch state this cycle
- Jump  in  1  absolute redirect to Target
- Target  in  D  jump destination
- Branch  in  1  relative redirect by Offset
- Offset  in  8  signed two's-complement branch displacement
- InstIn  in  9  ROM data for address PrgCtr (combinational ROM)
- PrgCtr  out  D  ROM address
- InstOut  out  9  registered instruction for decode
- InstAddr  out  D  address InstOut was fetched from
- InstValid  out  1  InstOut is live
- Busy  out  1  state == RUN
- Done  out  1  state == HALT
- CycleCount  out  16  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- Reset values: PrgCtr 0, InstOut 0, InstAddr 0, InstValid 0, Busy 0, Done 0, CycleCount 0.
- IDLE/HALT + Start: -> RUN; PrgCtr <= StartAddr; InstValid <= 0; CycleCount <= 0. Start in RUN ignored.
- RUN, per-cycle priority (highest first):
  - Halt: InstValid && InstOut == HALT_CODE -> HALT; InstValid <= 0; PrgCtr held. Overrides Stall, Jump, Branch.
  - Jump (only when InstValid): PrgCtr <= Target; InstValid <= 0.
  - Branch (only when InstValid): PrgCtr <= InstAddr + sext(Offset), modulo 2**D; InstValid <= 0.
  - Stall: PrgCtr, InstOut, InstAddr, InstValid held.
  - Sequential: InstOut <= InstIn; InstAddr <= PrgCtr; InstValid <= 1; PrgCtr <= PrgCtr + 1, modulo 2**D (2**D-1 wraps to 0).
- Jump and Branch together: Jump wins. Jump/Branch with InstValid == 0 ignored.
- Redirect squashes the sequentially fetched instruction: exactly one bubble.
- CycleCount increments every RUN cycle including stall/bubble/halt-detect cycles; holds at 16'hFFFF; holds in IDLE/HALT.
- Reset mid-RUN: next cycle IDLE with all reset values; in-flight instruction discarded.

## Timing
- Edge 0: Start sampled in IDLE -> state RUN, PrgCtr = StartAddr, InstValid 0.
- Edge 1: InstOut = ROM[StartAddr], InstAddr = StartAddr, InstValid 1, PrgCtr = StartAddr+1. Start-to-first-valid latency: 2 cycles.
- Sustained throughput: 1 instruction/cycle without stall or redirect.
- Redirect sampled at edge n -> InstValid 0 after edge n, first target instruction valid after edge n+1.
- HALT_CODE valid after edge n -> Done 1, Busy 0 after edge n+1.
- Outputs purely registered; no combinational input-to-output paths except PrgCtr->ROM->InstIn externally.

## Structure
- Package fetch_pkg: state enum (IDLE, RUN, HALT), HALT_CODE default, CYC_W = 16.
- One sub-module natural: pc_next_sel, combinational next-PC mux (start/jump/branch/increment, sign extension, wrap).
- ROM instantiated outside; bench connects instr_ROM-style combinational model.

## Test plan
- Reset, Start at StartAddr 0, ROM 0..4 = distinct codes, ROM[5] = 9'h1FF -> InstValid words in order with InstAddr 0..4, Done after 7 RUN cycles, CycleCount 7.
- Stall held 3 cycles while InstAddr 2 valid -> InstOut/InstAddr/PrgCtr frozen, CycleCount still +3.
- Jump Target 12'h100 while InstAddr 3 valid -> one bubble, next valid InstAddr 12'h100; same cycle Branch also asserted -> Jump taken.
- Branch Offset 8'hFE with InstAddr 12'h010 -> next valid InstAddr 12'h00E; Offset 8'h7F from 12'hFF0 -> 12'h06F (wrap).
- Sequential fetch from 12'hFFE -> InstAddr FFE, FFF, 000; Start during RUN ignored; Start in HALT restarts with CycleCount 0.
- Reset asserted mid-RUN -> next cycle IDLE, all outputs at reset values; cycle count saturation forced via 70000-cycle loop -> holds 16'hFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the ARMINx8 instruction-fetch
// sequencer.
//   D_DEF         default PC / ROM address width
//   HALT_CODE_DEF default machine code that terminates a program
//   CYC_W         width of the RUN-cycle counter
//   state_t       sequencer state (IDLE, RUN, HALT)
//   pc_sel_t      next-PC source chosen by the sequencer
package fetch_pkg;

    localparam int D_DEF = 12;
    localparam logic [8:0] HALT_CODE_DEF = 9'h1FF;
    localparam int CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_START  = 3'd1,
        PC_JUMP   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_INC    = 3'd4
    } pc_sel_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: control, ROM and decode-side signals of fetch_ctrl.
//   Harness side : Start, StartAddr, Stall, Jump, Target, Branch, Offset
//   ROM side     : PrgCtr (address out), InstIn (combinational ROM data in)
//   Decode side  : InstOut, InstAddr, InstValid
//   Status       : Busy, Done, CycleCount
// Modports:
//   master - the environment (harness, ROM, decoder)
//   slave  - the fetch sequencer
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int D = D_DEF
) ();

    logic             Start;
    logic [D-1:0]     StartAddr;
    logic             Stall;
    logic             Jump;
    logic [D-1:0]     Target;
    logic             Branch;
    logic [7:0]       Offset;
    logic [8:0]       InstIn;

    logic [D-1:0]     PrgCtr;
    logic [8:0]       InstOut;
    logic [D-1:0]     InstAddr;
    logic             InstValid;
    logic             Busy;
    logic             Done;
    logic [CYC_W-1:0] CycleCount;

    modport master (
        output Start, StartAddr, Stall, Jump, Target, Branch, Offset, InstIn,
        input  PrgCtr, InstOut, InstAddr, InstValid, Busy, Done, CycleCount
    );

    modport slave (
        input  Start, StartAddr, Stall, Jump, Target, Branch, Offset, InstIn,
        output PrgCtr, InstOut, InstAddr, InstValid, Busy, Done, CycleCount
    );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC multiplexer.
//   sel        next-PC source (hold / start / jump / branch / increment)
//   pc         current program counter
//   start_addr restart address
//   target     absolute jump destination
//   inst_addr  address of the instruction being branched from
//   offset     signed 8-bit branch displacement
//   next_pc    selected next PC; all arithmetic wraps modulo 2**D
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int D = D_DEF
) (
    input  pc_sel_t      sel,
    input  logic [D-1:0] pc,
    input  logic [D-1:0] start_addr,
    input  logic [D-1:0] target,
    input  logic [D-1:0] inst_addr,
    input  logic [7:0]   offset,
    output logic [D-1:0] next_pc
);

    logic [D-1:0] offset_sext;

    // Sign-extend then add at width D so the sum wraps naturally.
    assign offset_sext = {{(D-8){offset[7]}}, offset};

    always_comb begin
        next_pc = pc;
        case (sel)
            PC_START:  next_pc = start_addr;
            PC_JUMP:   next_pc = target;
            PC_BRANCH: next_pc = inst_addr + offset_sext;
            PC_INC:    next_pc = pc + D'(1);
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the ARMINx8 core.
// Owns the PC addressing the external combinational instruction ROM,
// registers the returned word for decode, and handles start, stall,
// absolute jump, PC-relative branch and halt. Counts RUN cycles
// (saturating) for run-length measurement.
//   Clk   system clock, all state on the rising edge
//   Reset synchronous, active-high
//   bus   fetch_ctrl_if.slave: harness controls, ROM address/data,
//         registered instruction, Busy/Done status, CycleCount
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int         D         = D_DEF,
    parameter logic [8:0] HALT_CODE = HALT_CODE_DEF
) (
    input logic        Clk,
    input logic        Reset,
    fetch_ctrl_if.slave bus
);

    state_t           state;
    logic [D-1:0]     pc;
    logic [D-1:0]     next_pc;
    logic [8:0]       inst_out;
    logic [D-1:0]     inst_addr;
    logic             inst_valid;
    logic [CYC_W-1:0] cycle_count;
    pc_sel_t          sel;
    logic             halt_hit;

    // Halt is detected on the registered word, so it outranks every
    // redirect or stall requested in the same cycle.
    assign halt_hit = inst_valid && (inst_out == HALT_CODE);

    // Priority: start (outside RUN); in RUN halt > jump > branch > stall > step.
    // Redirects need a live instruction; otherwise they are ignored.
    always_comb begin
        sel = PC_HOLD;
        if (state != RUN) begin
            if (bus.Start) sel = PC_START;
        end else if (halt_hit) begin
            sel = PC_HOLD;
        end else if (inst_valid && bus.Jump) begin
            sel = PC_JUMP;
        end else if (inst_valid && bus.Branch) begin
            sel = PC_BRANCH;
        end else if (!bus.Stall) begin
            sel = PC_INC;
        end
    end

    pc_next_sel #(
        .D (D)
    ) u_pc_next_sel (
        .sel        (sel),
        .pc         (pc),
        .start_addr (bus.StartAddr),
        .target     (bus.Target),
        .inst_addr  (inst_addr),
        .offset     (bus.Offset),
        .next_pc    (next_pc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= '0;
            inst_out    <= '0;
            inst_addr   <= '0;
            inst_valid  <= 1'b0;
            cycle_count <= '0;
        end else begin
            pc <= next_pc;
            case (state)
                IDLE, HALT: begin
                    if (bus.Start) begin
                        state       <= RUN;
                        inst_valid  <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                RUN: begin
                    if (cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
                    if (halt_hit) begin
                        state      <= HALT;
                        inst_valid <= 1'b0;
                    end else if (sel == PC_JUMP || sel == PC_BRANCH) begin
                        // Squash the word fetched from the old path: one bubble.
                        inst_valid <= 1'b0;
                    end else if (sel == PC_INC) begin
                        inst_out   <= bus.InstIn;
                        inst_addr  <= pc;
                        inst_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PrgCtr     = pc;
    assign bus.InstOut    = inst_out;
    assign bus.InstAddr   = inst_addr;
    assign bus.InstValid  = inst_valid;
    assign bus.Busy       = (state == RUN);
    assign bus.Done       = (state == HALT);
    assign bus.CycleCount = cycle_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A behavioural model
// of the sequencer is compared with the DUT every cycle; directed scenarios
// add hand-computed expectations, followed by a randomized phase and a
// cycle-counter saturation run.
module tb_fetch_ctrl;

    localparam int         D  = 12;
    localparam int         NA = 4096;
    localparam logic [8:0] HC = 9'h1FF;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    fetch_ctrl_if #(.D(D)) bus ();

    fetch_ctrl #(.D(D), .HALT_CODE(HC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [8:0] rom [NA];
    assign bus.InstIn = rom[bus.PrgCtr];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state;   // 0 idle, 1 run, 2 halted
    logic [11:0] m_pc, m_addr;
    logic [8:0]  m_out;
    logic        m_valid;
    int          m_cnt;
    int          m_t;

    always @(posedge Clk) begin
        if (Reset) begin
            m_state = 0; m_pc = '0; m_addr = '0; m_out = '0; m_valid = 1'b0; m_cnt = 0;
        end else if (m_state != 1) begin
            if (bus.Start) begin
                m_state = 1; m_pc = bus.StartAddr; m_valid = 1'b0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_valid && m_out == HC) begin
                m_state = 2; m_valid = 1'b0;
            end else if (m_valid && bus.Jump) begin
                m_pc = bus.Target; m_valid = 1'b0;
            end else if (m_valid && bus.Branch) begin
                m_t = int'(m_addr) + int'($signed(bus.Offset));
                m_pc = 12'((m_t + NA) % NA);
                m_valid = 1'b0;
            end else if (!bus.Stall) begin
                m_out = rom[m_pc]; m_addr = m_pc; m_valid = 1'b1;
                m_pc = 12'((int'(m_pc) + 1) % NA);
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("PrgCtr",     32'(bus.PrgCtr),     32'(m_pc));
            check("InstValid",  32'(bus.InstValid),  32'(m_valid));
            if (m_valid) begin
                check("InstOut",  32'(bus.InstOut),  32'(m_out));
                check("InstAddr", 32'(bus.InstAddr), 32'(m_addr));
            end
            check("Busy",       32'(bus.Busy),       32'(m_state == 1));
            check("Done",       32'(bus.Done),       32'(m_state == 2));
            check("CycleCount", 32'(bus.CycleCount), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start = 1'b0; bus.StartAddr = '0; bus.Stall = 1'b0; bus.Jump = 1'b0;
        bus.Target = '0; bus.Branch = 1'b0; bus.Offset = '0;
    endtask

    task automatic start_at(input logic [11:0] a);
        bus.Start = 1'b1; bus.StartAddr = a;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic run_to_done(input string name, input int budget);
        int n = 0;
        while (!bus.Done && n < budget) begin
            step();
            n++;
        end
        check({name, "_done"}, 32'(bus.Done), 32'd1);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < NA; i++) rom[i] = 9'($urandom % 511);
    endtask

    logic [8:0] prog [5];

    initial begin
        prog[0] = 9'h011; prog[1] = 9'h022; prog[2] = 9'h033; prog[3] = 9'h044; prog[4] = 9'h055;
        fill_rom();
        for (int i = 0; i < 5; i++) rom[i] = prog[i];
        rom[5]      = HC;
        rom[12'h101] = HC;
        rom[12'h00F] = HC;
        rom[12'h070] = HC;
        idle_inputs();

        Reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        Reset = 1'b0;
        check("rst_pc",   32'(bus.PrgCtr), 32'd0);
        check("rst_busy", 32'(bus.Busy),   32'd0);
        check("rst_done", 32'(bus.Done),   32'd0);

        // Straight-line program ending in the halt code at address 5.
        start_at(12'h000);
        check("p1_start_valid", 32'(bus.InstValid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("p1_addr", 32'(bus.InstAddr), 32'(i));
            check("p1_out",  32'(bus.InstOut),  32'(prog[i]));
        end
        step();
        check("p1_halt_word", 32'(bus.InstOut), 32'(HC));
        check("p1_not_done",  32'(bus.Done),    32'd0);
        step();
        check("p1_done",      32'(bus.Done),       32'd1);
        check("p1_busy",      32'(bus.Busy),       32'd0);
        check("p1_cnt",       32'(bus.CycleCount), 32'd7);
        check("p1_model_cnt", 32'(m_cnt),          32'd7);

        // Stall for 3 cycles with InstAddr 2 live; restart from HALT.
        start_at(12'h000);
        check("restart_cnt", 32'(bus.CycleCount), 32'd0);
        repeat (3) step();
        check("st_addr_pre", 32'(bus.InstAddr), 32'h2);
        bus.Stall = 1'b1;
        repeat (3) step();
        bus.Stall = 1'b0;
        check("st_addr", 32'(bus.InstAddr), 32'h2);
        check("st_out",  32'(bus.InstOut),  32'h033);
        check("st_pc",   32'(bus.PrgCtr),   32'h3);
        check("st_cnt",  32'(bus.CycleCount), 32'd6);
        run_to_done("st", 10);

        // Jump and Branch together with InstAddr 3 live: jump wins.
        start_at(12'h000);
        repeat (4) step();
        check("jb_addr_pre", 32'(bus.InstAddr), 32'h3);
        bus.Jump = 1'b1; bus.Branch = 1'b1; bus.Target = 12'h100; bus.Offset = 8'h05;
        step();
        bus.Jump = 1'b0; bus.Branch = 1'b0;
        check("jb_bubble", 32'(bus.InstValid), 32'd0);
        check("jb_pc",     32'(bus.PrgCtr),    32'h100);
        step();
        check("jb_valid",  32'(bus.InstValid), 32'd1);
        check("jb_addr",   32'(bus.InstAddr),  32'h100);
        run_to_done("jb", 10);

        // Backward branch -2 from 0x010.
        start_at(12'h010);
        step();
        bus.Branch = 1'b1; bus.Offset = 8'hFE;
        step();
        bus.Branch = 1'b0;
        check("br1_pc",   32'(bus.PrgCtr),   32'h00E);
        step();
        check("br1_addr", 32'(bus.InstAddr), 32'h00E);
        run_to_done("br1", 10);

        // Forward branch +127 from 0xFF0 wraps to 0x06F.
        start_at(12'hFF0);
        step();
        bus.Branch = 1'b1; bus.Offset = 8'h7F;
        step();
        bus.Branch = 1'b0;
        check("br2_pc",   32'(bus.PrgCtr),   32'h06F);
        step();
        check("br2_addr", 32'(bus.InstAddr), 32'h06F);
        run_to_done("br2", 10);

        // Sequential wrap FFE, FFF, 000; Start while running is ignored.
        start_at(12'hFFE);
        step();
        check("wr_a0", 32'(bus.InstAddr), 32'hFFE);
        bus.Start = 1'b1; bus.StartAddr = 12'h200;
        step();
        bus.Start = 1'b0;
        check("wr_a1", 32'(bus.InstAddr), 32'hFFF);
        step();
        check("wr_a2", 32'(bus.InstAddr), 32'h000);
        check("wr_pc", 32'(bus.PrgCtr),   32'h001);
        run_to_done("wr", 12);

        // Reset in the middle of a run.
        start_at(12'h400);
        repeat (3) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mr_pc",    32'(bus.PrgCtr),     32'd0);
        check("mr_valid", 32'(bus.InstValid),  32'd0);
        check("mr_out",   32'(bus.InstOut),    32'd0);
        check("mr_addr",  32'(bus.InstAddr),   32'd0);
        check("mr_busy",  32'(bus.Busy),       32'd0);
        check("mr_done",  32'(bus.Done),       32'd0);
        check("mr_cnt",   32'(bus.CycleCount), 32'd0);

        // Randomized phase: scattered halt codes, random controls.
        for (int i = 0; i < 24; i++) rom[$urandom % NA] = HC;
        for (int i = 0; i < 3000; i++) begin
            bus.Stall     = ($urandom % 4) == 0;
            bus.Jump      = ($urandom % 8) == 0;
            bus.Branch    = ($urandom % 6) == 0;
            bus.Target    = 12'($urandom);
            bus.Offset    = 8'($urandom);
            bus.Start     = ($urandom % 16) == 0;
            bus.StartAddr = 12'($urandom);
            Reset         = ($urandom % 500) == 0;
            step();
        end
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;

        // Counter saturation: no halt codes anywhere, run 70000 cycles.
        fill_rom();
        start_at(12'h000);
        repeat (70000) step();
        check("sat_cnt",  32'(bus.CycleCount), 32'hFFFF);
        check("sat_busy", 32'(bus.Busy),       32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
